// File: rtl/touch_scan_scheduler.sv
// touch_scan_scheduler: paces X/Y(/Z1) conversions while the pen is down and averages valid pairs.
// Optional pressure channel enabled by defining TOUCH_SCAN_PRESSURE_EN.
module touch_scan_scheduler #(
  parameter int SAMPLE_INTERVAL = 50000,
  parameter int AVG_LOG2 = 2,
  parameter int ACK_TIMEOUT = 4096,
  parameter logic [7:0] CMD_X = 8'h92,
  parameter logic [7:0] CMD_Y = 8'hD2
`ifdef TOUCH_SCAN_PRESSURE_EN
  , parameter logic [7:0] CMD_Z1 = 8'hB2,
  parameter logic [11:0] Z1_MIN = 12'd64
`endif
) (
  input  logic        csi_clk,
  input  logic        csi_reset,
  input  logic        enable,
  input  logic        pen_irq_n,
  output logic        conv_req,
  output logic [7:0]  conv_cmd,
  input  logic        conv_ack,
  input  logic [11:0] conv_result,
  output logic [11:0] coord_x,
  output logic [11:0] coord_y,
`ifdef TOUCH_SCAN_PRESSURE_EN
  output logic [11:0] coord_z,
`endif
  output logic        coord_valid,
  output logic        pen_down,
  output logic        timeout_err
);
  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int IW = $clog2(SAMPLE_INTERVAL);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam int CW = AVG_LOG2 + 1;
  typedef enum logic [3:0] {
    IDLE, REQ_X, WAIT_X, REQ_Y, WAIT_Y, ACCUM, INTERVAL
`ifdef TOUCH_SCAN_PRESSURE_EN
    , REQ_Z, WAIT_Z
`endif
  } state_t;
  state_t state_q, state_d;
  logic pen_s_q, pen_q;
  logic [IW-1:0] int_q, int_d;
  logic [AW-1:0] ack_q, ack_d;
  logic req_q, req_d, valid_q, valid_d, terr_q, terr_d;
  logic [7:0] cmd_q, cmd_d;
  logic [11:0] x_q, x_d, y_q, y_d, cx_q, cx_d, cy_q, cy_d;
  logic [ACC_W-1:0] accx_q, accx_d, accy_q, accy_d, sum_x, sum_y;
  logic [CW-1:0] cnt_q, cnt_d;
  logic go, tmo, waiting, ok_pair, full;
`ifdef TOUCH_SCAN_PRESSURE_EN
  logic [11:0] z_q, z_d, cz_q, cz_d;
  logic [ACC_W-1:0] accz_q, accz_d, sum_z;
  assign sum_z = accz_q + ACC_W'(z_q);
  assign ok_pair = |x_q && |y_q && (z_q >= Z1_MIN);
  assign waiting = state_q inside {WAIT_X, WAIT_Y, WAIT_Z};
  assign coord_z = cz_q;
`else
  assign ok_pair = |x_q && |y_q;
  assign waiting = state_q inside {WAIT_X, WAIT_Y};
`endif
  assign go = pen_q && enable;
  assign tmo = ack_q == AW'(ACK_TIMEOUT - 1);
  assign full = cnt_q == CW'((1 << AVG_LOG2) - 1);
  assign sum_x = accx_q + ACC_W'(x_q);
  assign sum_y = accy_q + ACC_W'(y_q);
  assign conv_req = req_q;
  assign conv_cmd = cmd_q;
  assign coord_x = cx_q;
  assign coord_y = cy_q;
  assign coord_valid = valid_q;
  assign pen_down = pen_q;
  assign timeout_err = terr_q;
  always_comb begin
    state_d = state_q;
    int_d = (int_q == IW'(SAMPLE_INTERVAL - 1)) ? int_q : int_q + IW'(1);
    ack_d = '0;
    req_d = req_q;
    cmd_d = cmd_q;
    valid_d = 1'b0;
    terr_d = enable ? terr_q : 1'b0;
    x_d = x_q;
    y_d = y_q;
    cx_d = cx_q;
    cy_d = cy_q;
    accx_d = accx_q;
    accy_d = accy_q;
    cnt_d = cnt_q;
`ifdef TOUCH_SCAN_PRESSURE_EN
    z_d = z_q;
    cz_d = cz_q;
    accz_d = accz_q;
`endif
    // an ack in the timeout cycle is still honoured; the case below picks the next state
    if (waiting) begin
      if (conv_ack) req_d = 1'b0;
      else if (tmo) begin
        req_d = 1'b0;
        terr_d = 1'b1;
        state_d = IDLE;
      end else ack_d = ack_q + AW'(1);
    end
    case (state_q)
      IDLE: begin
        accx_d = '0;
        accy_d = '0;
        cnt_d = '0;
`ifdef TOUCH_SCAN_PRESSURE_EN
        accz_d = '0;
`endif
        if (go) begin
          state_d = REQ_X;
          int_d = '0;
        end
      end
      REQ_X: begin
        req_d = 1'b1;
        cmd_d = CMD_X;
        state_d = WAIT_X;
      end
      WAIT_X: if (conv_ack) begin
        x_d = conv_result;
        state_d = go ? REQ_Y : IDLE;
      end
      REQ_Y: begin
        req_d = 1'b1;
        cmd_d = CMD_Y;
        state_d = WAIT_Y;
      end
`ifdef TOUCH_SCAN_PRESSURE_EN
      WAIT_Y: if (conv_ack) begin
        y_d = conv_result;
        state_d = go ? REQ_Z : IDLE;
      end
      REQ_Z: begin
        req_d = 1'b1;
        cmd_d = CMD_Z1;
        state_d = WAIT_Z;
      end
      WAIT_Z: if (conv_ack) begin
        z_d = conv_result;
        state_d = go ? ACCUM : IDLE;
      end
`else
      WAIT_Y: if (conv_ack) begin
        y_d = conv_result;
        state_d = go ? ACCUM : IDLE;
      end
`endif
      ACCUM: begin
        state_d = INTERVAL;
        if (ok_pair) begin
          accx_d = full ? '0 : sum_x;
          accy_d = full ? '0 : sum_y;
          cnt_d = full ? '0 : cnt_q + CW'(1);
          cx_d = full ? sum_x[ACC_W-1 -: 12] : cx_q;
          cy_d = full ? sum_y[ACC_W-1 -: 12] : cy_q;
          valid_d = full;
`ifdef TOUCH_SCAN_PRESSURE_EN
          accz_d = full ? '0 : sum_z;
          cz_d = full ? sum_z[ACC_W-1 -: 12] : cz_q;
`endif
        end
      end
      INTERVAL: if (int_q == IW'(SAMPLE_INTERVAL - 1)) begin
        state_d = go ? REQ_X : IDLE;
        int_d = go ? '0 : int_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge csi_clk or posedge csi_reset) begin
    if (csi_reset) begin
      state_q <= IDLE;
      pen_s_q <= 1'b0;
      pen_q <= 1'b0;
      int_q <= '0;
      ack_q <= '0;
      req_q <= 1'b0;
      cmd_q <= CMD_X;
      valid_q <= 1'b0;
      terr_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
      accx_q <= '0;
      accy_q <= '0;
      cnt_q <= '0;
`ifdef TOUCH_SCAN_PRESSURE_EN
      z_q <= '0;
      cz_q <= '0;
      accz_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pen_s_q <= ~pen_irq_n;
      pen_q <= pen_s_q;
      int_q <= int_d;
      ack_q <= ack_d;
      req_q <= req_d;
      cmd_q <= cmd_d;
      valid_q <= valid_d;
      terr_q <= terr_d;
      x_q <= x_d;
      y_q <= y_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
      accx_q <= accx_d;
      accy_q <= accy_d;
      cnt_q <= cnt_d;
`ifdef TOUCH_SCAN_PRESSURE_EN
      z_q <= z_d;
      cz_q <= cz_d;
      accz_q <= accz_d;
`endif
    end
  end
endmodule

// File: tb/tb_touch_scan_scheduler.sv
// tb_touch_scan_scheduler: scoreboard bench for touch_scan_scheduler (X/Y build).
module tb_touch_scan_scheduler;
  logic csi_clk = 1'b0, csi_reset = 1'b1, enable = 1'b0, pen_irq_n = 1'b1, conv_ack = 1'b0;
  logic [11:0] conv_result = '0;
  logic conv_req, coord_valid, pen_down, timeout_err;
  logic [7:0] conv_cmd;
  logic [11:0] coord_x, coord_y;
  typedef struct {logic [11:0] x; logic [11:0] y;} coord_t;
  coord_t exp_q[$];
  coord_t mon_e;
  int n_checks, n_errors, cyc, last_x;
  bit gap_on, ok;
  touch_scan_scheduler #(.SAMPLE_INTERVAL(100), .AVG_LOG2(2), .ACK_TIMEOUT(16)) dut (
    .csi_clk(csi_clk), .csi_reset(csi_reset), .enable(enable), .pen_irq_n(pen_irq_n),
    .conv_req(conv_req), .conv_cmd(conv_cmd), .conv_ack(conv_ack), .conv_result(conv_result),
    .coord_x(coord_x), .coord_y(coord_y), .coord_valid(coord_valid), .pen_down(pen_down),
    .timeout_err(timeout_err)
  );
  always #5 csi_clk = ~csi_clk;
  always @(posedge csi_clk) cyc++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  always @(negedge csi_clk) if (coord_valid) begin
    if (exp_q.size() == 0) check("coord_valid_unexpected", 1, 0);
    else begin
      mon_e = exp_q.pop_front();
      check("coord_x", coord_x, mon_e.x);
      check("coord_y", coord_y, mon_e.y);
    end
  end
  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge csi_clk);
      got = conv_req;
    end
    if (!got) check("req_wait", 0, 1);
  endtask
  task automatic serve(input logic [7:0] cmd, input logic [11:0] val, input int lat, input bit rel);
    bit got;
    wait_req(got);
    if (got) begin
      if (cmd == 8'h92) begin
        if (gap_on) check("x_req_interval", cyc - last_x, 100);
        last_x = cyc;
        gap_on = 1'b1;
      end
      check("conv_cmd", conv_cmd, cmd);
      if (rel) pen_irq_n = 1'b1;
      repeat (lat) @(negedge csi_clk);
      conv_ack = 1'b1;
      conv_result = val;
      @(negedge csi_clk);
      conv_ack = 1'b0;
      check("req_drop", conv_req, 0);
    end
  endtask
  task automatic pair(input logic [11:0] x, input logic [11:0] y);
    serve(8'h92, x, 0, 0);
    serve(8'hD2, y, 0, 0);
  endtask
  initial begin
    repeat (3) @(negedge csi_clk);
    check("rst_conv_req", conv_req, 0);
    check("rst_conv_cmd", conv_cmd, 8'h92);
    check("rst_coord_x", coord_x, 0);
    check("rst_coord_y", coord_y, 0);
    check("rst_valid", coord_valid, 0);
    check("rst_pen_down", pen_down, 0);
    check("rst_timeout", timeout_err, 0);
    csi_reset = 1'b0;
    enable = 1'b1;
    pen_irq_n = 1'b0;
    @(negedge csi_clk);
    check("pen_sync_lag1", pen_down, 0);
    @(negedge csi_clk);
    check("pen_sync_lag2", pen_down, 1);
    exp_q.push_back('{12'd100, 12'd200});
    pair(100, 200); pair(104, 200); pair(96, 204); pair(100, 196);
    exp_q.push_back('{12'd25, 12'd400});
    pair(10, 400); pair(0, 500); pair(20, 400); pair(7, 0); pair(30, 400); pair(41, 403);
    pair(3000, 3000); pair(3000, 3000);
    serve(8'h92, 3000, 0, 0);
    serve(8'hD2, 3000, 3, 1);
    repeat (150) @(negedge csi_clk);
    check("abort_idle_req", conv_req, 0);
    check("abort_keep_x", coord_x, 25);
    check("abort_keep_y", coord_y, 400);
    check("abort_pen_down", pen_down, 0);
    gap_on = 1'b0;
    pen_irq_n = 1'b0;
    exp_q.push_back('{12'd1001, 12'd2001});
    pair(1000, 2000); pair(1000, 2001); pair(1000, 2002); pair(1004, 2003);
    wait_req(ok);
    if (ok) begin
      int hi;
      check("tmo_cmd", conv_cmd, 8'h92);
      pen_irq_n = 1'b1;
      hi = 1;
      for (int i = 0; i < 40 && conv_req; i++) begin
        @(negedge csi_clk);
        if (conv_req) hi++;
      end
      check("tmo_req_len", hi, 16);
      check("tmo_err_set", timeout_err, 1);
      repeat (3) @(negedge csi_clk);
      conv_ack = 1'b1;
      conv_result = 12'd55;
      @(negedge csi_clk);
      conv_ack = 1'b0;
      repeat (10) @(negedge csi_clk);
      check("late_ack_req", conv_req, 0);
      check("late_ack_sticky", timeout_err, 1);
      check("late_ack_x", coord_x, 1001);
    end
    enable = 1'b0;
    repeat (2) @(negedge csi_clk);
    check("tmo_err_clear", timeout_err, 0);
    enable = 1'b1;
    pen_irq_n = 1'b0;
    wait_req(ok);
    @(negedge csi_clk);
    csi_reset = 1'b1;
    #1;
    check("mid_rst_req", conv_req, 0);
    check("mid_rst_cmd", conv_cmd, 8'h92);
    check("mid_rst_x", coord_x, 0);
    check("mid_rst_y", coord_y, 0);
    check("mid_rst_pen", pen_down, 0);
    check("mid_rst_valid", coord_valid, 0);
    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
